// File: rtl/multi_clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// Rate constants are divisor values for a 100 MHz system clock.
package multi_clk_div_pkg;

  localparam int unsigned DIV_W_DEF    = 29;
  localparam int unsigned DIV_INIT_DEF = 100_000_000;
  localparam int unsigned CLK_HZ_DEF   = 100_000_000;

  // Divisor values for common game/scan/debug rates: clk_hz/(2*hz)-1
  localparam int unsigned RATE_DIV_0P5HZ = 99_999_999;
  localparam int unsigned RATE_DIV_1HZ   = 49_999_999;
  localparam int unsigned RATE_DIV_2HZ   = 24_999_999;
  localparam int unsigned RATE_DIV_5HZ   = 9_999_999;
  localparam int unsigned RATE_DIV_10HZ  = 4_999_999;
  localparam int unsigned RATE_DIV_20HZ  = 2_499_999;
  localparam int unsigned RATE_DIV_50HZ  = 999_999;
  localparam int unsigned RATE_DIV_100HZ = 499_999;

  function automatic logic [DIV_W_DEF-1:0] rate_to_div(input longint unsigned hz,
                                                       input longint unsigned clk_hz);
    return DIV_W_DEF'(clk_hz / (64'd2 * hz) - 64'd1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, glitch-free toggle and tick.
// Optional phase-alignment input enabled by MULTI_CLK_DIV_SYNC_EN.
module clk_div_chan
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
`ifdef MULTI_CLK_DIV_SYNC_EN
  input  logic             i_sync,
`endif
  input  logic             i_en,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_clk_out,
  output logic             o_tick,
  output logic             o_busy
);

  logic [DIV_W-1:0] r_cnt, r_div, r_pend;
  logic             r_clk_out, r_tick, r_busy;

  logic [DIV_W-1:0] w_cnt_nxt, w_div_nxt, w_pend_nxt;
  logic             w_clk_nxt, w_tick_nxt, w_busy_nxt;
  logic             w_term;
  logic             w_sync;

`ifdef MULTI_CLK_DIV_SYNC_EN
  assign w_sync = i_sync;
`else
  assign w_sync = 1'b0;
`endif

  assign w_term = (r_cnt == r_div);

  // Next state; a new divisor is only adopted at the falling edge ending a period
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_div_nxt  = r_div;
    w_pend_nxt = r_pend;
    w_clk_nxt  = r_clk_out;
    w_tick_nxt = 1'b0;
    w_busy_nxt = r_busy;

    if (!i_en || w_sync) begin
      w_cnt_nxt  = '0;
      w_clk_nxt  = 1'b0;
      w_div_nxt  = r_pend;
      w_busy_nxt = 1'b0;
    end else if (w_term) begin
      w_cnt_nxt  = '0;
      w_clk_nxt  = ~r_clk_out;
      w_tick_nxt = ~r_clk_out;
      if (r_clk_out) begin
        w_div_nxt  = r_pend;
        w_busy_nxt = 1'b0;
      end
    end else begin
      w_cnt_nxt = r_cnt + DIV_W'(1);
    end

    // A load landing on an apply cycle becomes the next pending value
    if (i_load) begin
      w_pend_nxt = i_div;
      w_busy_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_div     <= DIV_W'(DIV_INIT);
      r_pend    <= DIV_W'(DIV_INIT);
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_pend    <= w_pend_nxt;
      r_clk_out <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_busy    = r_busy;

endmodule

// File: rtl/multi_clk_div.sv
// NUM_CH independent programmable clock dividers sharing one system clock.
// Define MULTI_CLK_DIV_SYNC_EN to add the i_sync phase-alignment input.
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
`ifdef MULTI_CLK_DIV_SYNC_EN
  input  logic                    i_sync,
`endif
  input  logic [NUM_CH-1:0]       i_en,
  input  logic [NUM_CH-1:0]       i_load,
  input  logic [NUM_CH*DIV_W-1:0] i_div_in,
  output logic [NUM_CH-1:0]       o_clk_out,
  output logic [NUM_CH-1:0]       o_tick,
  output logic [NUM_CH-1:0]       o_busy
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
`ifdef MULTI_CLK_DIV_SYNC_EN
      .i_sync    (i_sync),
`endif
      .i_en      (i_en[g]),
      .i_load    (i_load[g]),
      .i_div     (i_div_in[g*DIV_W +: DIV_W]),
      .o_clk_out (o_clk_out[g]),
      .o_tick    (o_tick[g]),
      .o_busy    (o_busy[g])
    );
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Scoreboard bench for multi_clk_div: a waveform-queue reference model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_multi_clk_div;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned DIV_W    = 8;
  localparam int unsigned DIV_INIT = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       en = '0;
  logic [NUM_CH-1:0]       load = '0;
  logic [NUM_CH*DIV_W-1:0] div_in = '0;
  logic                    sync = 1'b0;
  logic [NUM_CH-1:0]       clk_out, tick, busy;

  multi_clk_div #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .DIV_INIT (DIV_INIT)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
`ifdef MULTI_CLK_DIV_SYNC_EN
    .i_sync    (sync),
`endif
    .i_en      (en),
    .i_load    (load),
    .i_div_in  (div_in),
    .o_clk_out (clk_out),
    .o_tick    (tick),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   gen_done = 1'b0;

  // Reference model: each channel holds the list of future output levels
  int   m_div  [NUM_CH];
  int   m_pend [NUM_CH];
  bit   m_busy [NUM_CH];
  bit   m_lvl  [NUM_CH];
  bit   m_wave [NUM_CH][$];

  function automatic void queue_period(int c, int lows);
    m_wave[c].delete();
    for (int k = 0; k < lows; k++) m_wave[c].push_back(1'b0);
    for (int k = 0; k <= m_div[c]; k++) m_wave[c].push_back(1'b1);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_div[c]  = DIV_INIT;
      m_pend[c] = DIV_INIT;
      m_busy[c] = 1'b0;
      m_lvl[c]  = 1'b0;
      // The reset state already shows the first low cycle of a period
      queue_period(c, m_div[c]);
    end
  endfunction

  function automatic exp_t model_step(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] l,
                                      input logic [NUM_CH*DIV_W-1:0] d, input logic s);
    exp_t r;
    bit   nl;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!e[c] || s) begin
        m_div[c]  = m_pend[c];
        m_busy[c] = 1'b0;
        queue_period(c, m_div[c]);
        nl = 1'b0;
      end else begin
        if (m_wave[c].size() == 0) begin
          m_div[c]  = m_pend[c];
          m_busy[c] = 1'b0;
          queue_period(c, m_div[c] + 1);
        end
        nl = m_wave[c].pop_front();
      end
      if (l[c]) begin
        m_pend[c] = int'(d[c*DIV_W +: DIV_W]);
        m_busy[c] = 1'b1;
      end
      r.clk_out[c] = nl;
      r.tick[c]    = nl & ~m_lvl[c];
      r.busy[c]    = m_busy[c];
      m_lvl[c]     = nl;
    end
    return r;
  endfunction

  function automatic logic [NUM_CH*DIV_W-1:0] pack4(int d0, int d1, int d2, int d3);
    logic [NUM_CH*DIV_W-1:0] v;
    v = '0;
    v[0*DIV_W +: DIV_W] = DIV_W'(d0);
    v[1*DIV_W +: DIV_W] = DIV_W'(d1);
    v[2*DIV_W +: DIV_W] = DIV_W'(d2);
    v[3*DIV_W +: DIV_W] = DIV_W'(d3);
    return v;
  endfunction

  task automatic check(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  task automatic cycle(input logic [NUM_CH-1:0] e, input logic [NUM_CH-1:0] l,
                       input logic [NUM_CH*DIV_W-1:0] d, input logic s);
    @(negedge clk);
    en     = e;
    load   = l;
    div_in = d;
    sync   = s;
    exp_q.push_back(model_step(e, l, d, s));
  endtask

  task automatic idle(input logic [NUM_CH-1:0] e, input int n);
    for (int i = 0; i < n; i++) cycle(e, '0, '0, 1'b0);
  endtask

  // Assert reset off the clock edge, check the asynchronous clear, then release
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = '0;
    load  = '0;
    sync  = 1'b0;
    #1;
    check("rst_clk_out", clk_out, '0);
    check("rst_tick", tick, '0);
    check("rst_busy", busy, '0);
    model_reset();
    @(negedge clk);
    check("rst_hold_clk_out", clk_out, '0);
    rst_n = 1'b1;
    exp_q.push_back(model_step('0, '0, '0, 1'b0));
  endtask

  // Monitor: every cycle the DUT presents outputs, pop and compare
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("clk_out", clk_out, x.clk_out);
        check("tick", tick, x.tick);
        check("busy", busy, x.busy);
      end
    end
  end

  initial begin
    logic [NUM_CH-1:0]       e, l;
    logic [NUM_CH*DIV_W-1:0] d;
    logic                    s;

    model_reset();
    do_reset();

    // DIV_INIT=2 free run: 3 low / 3 high
    idle('1, 14);

    // Divisors 0/1/2/3 across channels
    cycle('1, '1, pack4(0, 1, 2, 3), 1'b0);
    idle('1, 30);

    // Reprogram ch3 (Div 3) to 1 during its high phase
    while (!clk_out[3] || tick[3]) idle('1, 1);
    cycle('1, 4'b1000, pack4(0, 0, 0, 1), 1'b0);
    idle('1, 20);

    // Two loads in one period on ch1: only the last one sticks
    cycle('1, 4'b0010, pack4(0, 5, 0, 0), 1'b0);
    idle('1, 1);
    cycle('1, 4'b0010, pack4(0, 0, 0, 0), 1'b0);
    idle('1, 16);

    // Disable ch2 mid-run, load while disabled, re-enable
    idle(4'b1011, 3);
    cycle(4'b1011, 4'b0100, pack4(0, 0, 4, 0), 1'b0);
    idle(4'b1011, 2);
    idle('1, 24);

    // Largest divisor on ch0
    cycle('1, 4'b0001, pack4(255, 0, 0, 0), 1'b0);
    idle('1, 600);

    // Reset while channels are mid-period
    do_reset();
    idle('1, 10);

`ifdef MULTI_CLK_DIV_SYNC_EN
    cycle('1, '1, pack4(1, 2, 0, 3), 1'b0);
    idle('1, 17);
    cycle('1, '0, '0, 1'b1);
    idle('1, 10);
`endif

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      e = '0;
      l = '0;
      d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        e[c] = ($urandom_range(0, 99) < 94);
        l[c] = ($urandom_range(0, 99) < 4);
        d[c*DIV_W +: DIV_W] = ($urandom_range(0, 199) == 0) ? DIV_W'(255)
                                                             : DIV_W'($urandom_range(0, 6));
      end
      s = 1'b0;
`ifdef MULTI_CLK_DIV_SYNC_EN
      s = ($urandom_range(0, 99) < 2);
`endif
      cycle(e, l, d, s);
      if (i == 2000) do_reset();
    end

    gen_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_clk_div.md
# multi_clk_div

Parametrised multi-channel programmable clock divider. It generates NUM_CH independent, glitch-free divided square waves from the system clock. Each channel's divisor can be reprogrammed at runtime through a load strobe. A new divisor takes effect only at a period boundary, so there is no runt or stretched pulse and no mid-period restart. The block sits between the speed-select/control logic and the timing consumers: game-tick, display scan and debug-rate clocks.

## Interface
- NUM_CH, 4, number of independent divider channels (1..16)
- DIV_W, 29, divisor/counter width in bits
- DIV_INIT, 100000000, divisor loaded into every channel at reset; must fit DIV_W
- Clk  input  1  system clock; all state updates on its rising edge
- Rst  input  1  reset, asynchronous, active-low
- En  input  NUM_CH  per-channel run enable
- Load  input  NUM_CH  per-channel one-cycle divisor load strobe
- DivIn  input  NUM_CH*DIV_W  divisor values; channel i uses DivIn[i*DIV_W +: DIV_W]
- ClkOut  output  NUM_CH  divided square waves, registered
- Tick  output  NUM_CH  one-cycle pulse, coincident with each ClkOut rising edge
- Busy  output  NUM_CH  divisor load pending, not yet applied
- Sync  input  1  present only with MULTI_CLK_DIV_SYNC_EN

## Operation
- Per channel state: Cnt[DIV_W], Div[DIV_W] (active), Pend[DIV_W], Busy, ClkOut, Tick.
- Reset (Rst=0): Cnt=0, Div=Pend=DIV_INIT, ClkOut=0, Tick=0, Busy=0. All outputs are 0 during reset.
- Run, En[i]=1:
  - If Cnt!=Div: Cnt+=1.
  - If Cnt==Div: Cnt=0 and ClkOut toggles.
  - Half period is Div+1 cycles; full period is 2*(Div+1). Div=0 gives Clk/2.
- Tick=1 on exactly the cycles where ClkOut goes 0->1; otherwise 0.
- Load[i]=1: Pend=DivIn slice, Busy=1. Last load wins while pending.
- Apply: on the terminal cycle (Cnt==Div) with ClkOut=1, i.e. the falling edge ending a full period:
  - Div=Pend, Busy=0.
  - The new period starts low with the new Div.
- Load on the same cycle as Apply: the old Pend is applied and the new value becomes Pend; Busy stays 1.
- En[i]=0:
  - Cnt=0 and ClkOut=0 on the next edge; Tick=0.
  - Any pending divisor is applied immediately and Busy clears (fast path).
  - Load while disabled applies on the following edge.
- En 0->1: counting resumes from Cnt=0 with ClkOut low.
- Divisor arithmetic is unsigned. DivIn=0 is legal. DivIn=2^DIV_W-1 is legal; Cnt never wraps past Div.
- Channels are fully independent; there is no shared state except Clk, Rst and Sync.

## Timing
- ClkOut, Tick and Busy are registered and change only on the Clk rising edge, or asynchronously on Rst assertion.
- With En held at 1 from reset release, ClkOut first rises after Div+1 rising edges, and Tick pulses on that same cycle.
- Busy asserts 1 cycle after Load. Worst-case apply latency is 2*(Div_old+1) cycles.
- Rst assertion mid-period clears immediately; there is no pending carry-over.

## Configuration
- MULTI_CLK_DIV_SYNC_EN defined:
  - Adds input Sync.
  - A one-cycle pulse restarts every enabled channel on the next edge: Cnt=0, ClkOut=0, pending divisor applied, Busy=0. All channels become phase-aligned.
  - A Load on the same cycle as Sync becomes the new Pend; Busy=1.
  - Sync takes precedence over the terminal-count toggle. Disabled channels ignore Sync.
- Not defined: no Sync port, and no phase-alignment logic is synthesised.

## Structure
- Package multi_clk_div_pkg holds:
  - default constants DIV_W_DEF=29 and DIV_INIT_DEF=100000000;
  - the named rate constants (0.5 Hz ... 100 Hz divisor values at 100 MHz) used by speed-select logic;
  - a function rate_to_div(hz, clk_hz) returning clk_hz/(2*hz)-1.
- Sub-module clk_div_chan implements one channel: counter, active/pending registers, toggle and Tick logic.
- The top level is a generate loop of NUM_CH instances plus bus slicing.

## Test plan
- Reset, then En=1 with DIV_INIT overridden to 2 -> ClkOut reads 0,0,0,1,1,1 repeating; Tick=1 every 6th cycle, aligned with the rise; Busy=0.
- Div=3, Load DivIn=1 in mid-high half -> ClkOut completes the current high phase of 4 cycles; from the falling edge the period is 4 cycles (2 low/2 high); Busy clears on that falling edge.
- Two Loads (5 then 0) within one period -> only 0 is applied; output becomes Clk/2 (1 low/1 high) after the boundary.
- Four channels with Div 0/1/2/3, En=1 -> periods of 2/4/6/8 cycles; toggling En[2] to 0 forces ClkOut[2]=0 next edge while the others are unaffected.
- Rst pulsed low mid-high phase -> all ClkOut, Tick and Busy equal 0 immediately; Div returns to DIV_INIT.
- With MULTI_CLK_DIV_SYNC_EN, channels with Div 1 and 2 free-running, then Sync pulse -> both ClkOut equal 0 next edge and rise 2 and 3 cycles later respectively; Tick is coincident with each rise.
